// File: rtl/gate_vector_checker_if.sv
// Handshake/result bundle between a gate_vector_checker and its environment.
// Optional first-fail signals exist only with GATE_VECTOR_CHECKER_FIRST_FAIL_EN.
interface gate_vector_checker_if;
   logic       start;
   logic       a_out;
   logic       b_out;
   logic       dut_y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_cnt;
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
   logic [1:0] fail_vec;
   logic       fail_valid;

   modport master (output start, dut_y,
                   input  a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_valid);
   modport slave  (input  start, dut_y,
                   output a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_valid);
`else
   modport master (output start, dut_y,
                   input  a_out, b_out, busy, done, pass, err_cnt);
   modport slave  (input  start, dut_y,
                   output a_out, b_out, busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps {a,b} through 00..11 with a per-vector dwell, checks a 2-input gate against EXPECT.
// Optional first-mismatch capture enabled by GATE_VECTOR_CHECKER_FIRST_FAIL_EN.
module gate_vector_checker #(
   parameter int          DWELL  = 4,
   parameter logic [3:0]  EXPECT = 4'b0111,
   parameter int          SWEEPS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   gate_vector_checker_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [7:0] DLAST = 8'(DWELL - 1);
   localparam logic [3:0] SLAST = 4'(SWEEPS - 1);

   logic [1:0] state;
   logic [1:0] vec;
   logic [7:0] dcnt;
   logic [3:0] scnt;
   logic [3:0] err_cnt;
   logic       a_r;
   logic       b_r;
   logic       sample;
   logic       mismatch;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Only the last dwell cycle is sampled, so settling glitches never count.
   assign sample   = (state == S_DRIVE) && (dcnt == DLAST);
   assign mismatch = sample && (bus.dut_y != EXPECT[vec]);

`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
   logic [1:0] fail_vec;
   logic       fail_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_vec   <= 2'b00;
         fail_valid <= 1'b0;
      end else if (state != S_DRIVE && bus.start) begin
         fail_vec   <= 2'b00;
         fail_valid <= 1'b0;
      end else if (mismatch && !fail_valid) begin
         fail_vec   <= vec;
         fail_valid <= 1'b1;
      end
   end

   assign bus.fail_vec   = fail_vec;
   assign bus.fail_valid = fail_valid;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         vec     <= 2'b00;
         dcnt    <= 8'd0;
         scnt    <= 4'd0;
         err_cnt <= 4'd0;
         a_r     <= 1'b0;
         b_r     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state   <= S_DRIVE;
                  vec     <= 2'b00;
                  dcnt    <= 8'd0;
                  scnt    <= 4'd0;
                  err_cnt <= 4'd0;
                  a_r     <= 1'b0;
                  b_r     <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (dcnt == DLAST) begin
                  dcnt       <= 8'd0;
                  vec        <= vec + 2'd1;
                  {a_r, b_r} <= vec + 2'd1;
                  if (mismatch)
                     err_cnt <= sat_inc(err_cnt);
                  if (vec == 2'b11) begin
                     if (scnt == SLAST) begin
                        state <= S_DONE;
                        a_r   <= 1'b0;
                        b_r   <= 1'b0;
                     end else begin
                        scnt <= scnt + 4'd1;
                     end
                  end
               end else begin
                  dcnt <= dcnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.a_out   = a_r;
   assign bus.b_out   = b_r;
   assign bus.busy    = (state == S_DRIVE);
   assign bus.done    = (state == S_DONE);
   assign bus.pass    = (state == S_DONE) && (err_cnt == 4'd0);
   assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: default NAND checker plus a saturating
// SWEEPS=15 instance driven by a stuck-at-1 gate.
module tb_gate_vector_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gate_and = 1'b0;
   logic glitch = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   gate_vector_checker_if ifc ();
   gate_vector_checker_if ifc2 ();

   // Gate under test: NAND normally, AND when gate_and, optional inverted glitch.
   assign ifc.dut_y  = (gate_and ? (ifc.a_out & ifc.b_out) : ~(ifc.a_out & ifc.b_out)) ^ glitch;
   assign ifc2.dut_y = 1'b1;

   gate_vector_checker u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   gate_vector_checker #(.DWELL(4), .EXPECT(4'b0000), .SWEEPS(15)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (ifc2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One default run; c is the cycle index after the start edge.
   task automatic run_default(input string tag, input bit glitch_en, input bit repulse,
                              input logic [3:0] exp_err);
      ifc.start = 1'b1;
      glitch = 1'b0;
      tick();
      ifc.start = 1'b0;
      check({tag, "_busy0"}, 32'(ifc.busy), 32'd1);
      check({tag, "_done_drop"}, 32'(ifc.done), 32'd0);
      for (int c = 0; c < 16; c++) begin
         if (c % 4 == 0)
            check($sformatf("%s_vec%0d", tag, c / 4), 32'({ifc.a_out, ifc.b_out}), 32'(c / 4));
         if (c == 3)
            check({tag, "_err_c3"}, 32'(ifc.err_cnt), 32'd0);
         if (c == 4 && exp_err != 4'd0)
            check({tag, "_err_c4"}, 32'(ifc.err_cnt), 32'd1);
         if (c == 15)
            check({tag, "_done_c15"}, 32'(ifc.done), 32'd0);
         glitch = glitch_en && (c % 4 == 0);
         ifc.start = repulse && (c == 5);
         tick();
      end
      glitch = 1'b0;
      ifc.start = 1'b0;
      check({tag, "_done"}, 32'(ifc.done), 32'd1);
      check({tag, "_busy_end"}, 32'(ifc.busy), 32'd0);
      check({tag, "_err"}, 32'(ifc.err_cnt), 32'(exp_err));
      check({tag, "_pass"}, 32'(ifc.pass), (exp_err == 4'd0) ? 32'd1 : 32'd0);
      check({tag, "_ab_end"}, 32'({ifc.a_out, ifc.b_out}), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_a"}, 32'(ifc.a_out), 32'd0);
      check({tag, "_b"}, 32'(ifc.b_out), 32'd0);
      check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
      check({tag, "_done"}, 32'(ifc.done), 32'd0);
      check({tag, "_pass"}, 32'(ifc.pass), 32'd0);
      check({tag, "_err"}, 32'(ifc.err_cnt), 32'd0);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
      check({tag, "_fvec"}, 32'(ifc.fail_vec), 32'd0);
      check({tag, "_fvalid"}, 32'(ifc.fail_valid), 32'd0);
`endif
   endtask

   initial begin
      int c;
      ifc.start  = 1'b0;
      ifc2.start = 1'b0;
      tick();
      tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // Correct NAND gate.
      run_default("nand", 1'b0, 1'b0, 4'd0);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
      check("nand_fvalid", 32'(ifc.fail_valid), 32'd0);
`endif
      tick();
      check("nand_done_hold", 32'(ifc.done), 32'd1);

      // AND gate against NAND truth table: every vector mismatches.
      gate_and = 1'b1;
      run_default("and", 1'b0, 1'b0, 4'd4);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
      check("and_fvec", 32'(ifc.fail_vec), 32'd0);
      check("and_fvalid", 32'(ifc.fail_valid), 32'd1);
`endif
      gate_and = 1'b0;

      // Settling glitches plus a start re-pulse mid-run.
      run_default("glitch", 1'b1, 1'b1, 4'd0);

      // Reset asserted during cycle 7 of a run.
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("rst_mid_vec", 32'({ifc.a_out, ifc.b_out}), 32'd1);
      check("rst_mid_busy", 32'(ifc.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("rst_mid");
      tick();
      check("rst_idle_busy", 32'(ifc.busy), 32'd0);
      run_default("after_rst", 1'b0, 1'b0, 4'd0);

      // rst and start together: rst wins.
      rst = 1'b1;
      ifc.start = 1'b1;
      tick();
      rst = 1'b0;
      ifc.start = 1'b0;
      check_reset_vals("rst_start");
      tick();
      check("rst_start_busy", 32'(ifc.busy), 32'd0);

      // Saturation: 60 mismatches, counter stops at 15, done at cycle 240.
      ifc2.start = 1'b1;
      tick();
      ifc2.start = 1'b0;
      c = 0;
      while (ifc2.done !== 1'b1 && c < 300) begin
         if (c == 56) check("sat_err56", 32'(ifc2.err_cnt), 32'd14);
         if (c == 60) check("sat_err60", 32'(ifc2.err_cnt), 32'd15);
         tick();
         c++;
      end
      check("sat_done_cycle", 32'(c), 32'd240);
      check("sat_done", 32'(ifc2.done), 32'd1);
      check("sat_err", 32'(ifc2.err_cnt), 32'd15);
      check("sat_pass", 32'(ifc2.pass), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus stage for the 2-input basic-gate labs. It sits directly upstream of a gate under test, driving its `a`/`b` inputs, and consumes the gate's output. It sweeps all four input combinations, holds each for a programmable dwell, samples the gate output, and compares it against a parameterised truth table. It reports pass/fail and a mismatch count, so gate exercises (AND, NOT-of-AND, NAND, …) are checked in hardware instead of by reading `$monitor` logs.

## Interface
- `DWELL`, default 4: cycles each vector is held; legal range 2..255.
- `EXPECT`, default 4'b0111: expected gate output; bit i is the output for {a,b}=i (the default is NAND).
- `SWEEPS`, default 1: number of full 00→11 sweeps per run; legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a run.
- `a_out` output 1: drives gate input a.
- `b_out` output 1: drives gate input b.
- `dut_y` input 1: gate output under test.
- `busy` output 1: run in progress.
- `done` output 1: run finished; held until next start or reset.
- `pass` output 1: valid while `done`=1; 1 when `err_cnt`==0.
- `err_cnt` output 4: mismatch count, saturating at 15.
- `fail_vec` output 2: {a,b} of first mismatch (only with macro, see Configuration).
- `fail_valid` output 1: `fail_vec` holds a captured value (only with macro).

## Operation
- States are IDLE, DRIVE, DONE.
- IDLE:
  - `a_out`=`b_out`=0, `busy`=0.
  - `start`=1 → DRIVE; clears `err_cnt`, vector index `vec`=0, dwell counter `dcnt`=0, sweep counter `scnt`=0.
- DRIVE:
  - `{a_out,b_out}` = `vec`, registered. `busy`=1.
  - `dcnt` increments each cycle.
  - When `dcnt`==DWELL-1, sample `dut_y` and compare it with `EXPECT[vec]`. On mismatch, `err_cnt` increments unless it is already 15.
  - On that same cycle, `dcnt`←0 and `vec`←`vec`+1 (wraps 3→0).
  - When `vec` wraps, `scnt` increments. When `scnt` reaches SWEEPS-1 at wrap, go to DONE.
- DONE:
  - `busy`=0, `done`=1, `a_out`=`b_out`=0, `pass`=(`err_cnt`==0).
  - `start`=1 → DRIVE with the same clears as from IDLE; `done` drops the same cycle.
- `start` while in DRIVE is ignored; the run is not restarted.
- `dut_y` is only sampled on the last dwell cycle. Mismatches on settling cycles are ignored.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `fail_valid`=0. State is IDLE.
- `rst` asserted mid-run aborts on the next edge to these values; no partial result is reported.
- `rst` and `start` asserted in the same cycle: `rst` wins.
- Cycle 0 is the edge where `start` is sampled. `busy`=1 and the vector 00 appear at the outputs after that edge.
- Vector k is present for exactly DWELL cycles.
- The sample for vector k is taken at the edge ending its DWELL-th cycle. This gives DWELL-1 cycles of settle for combinational or registered gates.
- Run length is 4·DWELL·SWEEPS cycles from `start` to `done`=1. The default parameters give 16 cycles.
- `err_cnt` updates on the sample edge and is visible the next cycle. The final count is stable when `done` rises.

## Configuration
- Macro: `GATE_VECTOR_CHECKER_FIRST_FAIL_EN`.
- Defined:
  - On the first mismatch of a run, `fail_vec`←sampled vector and `fail_valid`←1.
  - Later mismatches do not overwrite these.
  - Both clear on `start` and on `rst`.
- Undefined: `fail_vec` and `fail_valid` ports and logic are absent. The port list ends at `err_cnt`.

## Test plan
- Correct NAND, defaults: pulse `start` → `a_out`/`b_out` step through 00, 01, 10, 11 at 4 cycles each; `done`=1 at cycle 16, `pass`=1, `err_cnt`=0.
- Gate that is AND instead of NAND, `EXPECT`=4'b0111 → `err_cnt`=4, `pass`=0; with macro defined, `fail_vec`=2'b00 and `fail_valid`=1.
- `dut_y` stuck at 1, `SWEEPS`=15, `EXPECT`=4'b0000 → 60 mismatches; `err_cnt` saturates at 15, `done` arrives at cycle 240.
- `rst` pulsed at cycle 7 of a run → next cycle all outputs at reset values and state is IDLE; a new `start` completes normally in 16 cycles.
- Glitch on `dut_y` during the first cycle of each dwell only, with a correct gate → `err_cnt`=0, `pass`=1. Also, `start` re-pulsed mid-run → ignored; `done` still arrives at cycle 16.
